// File: rtl/cpu_register_if.sv
// Control/data bundle for one cpu_register instance.
// The master side drives the controls; the register answers on out_o.
interface cpu_register_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cl_i;
  logic                  ld_i;
  logic [DATA_WIDTH-1:0] in_i;
  logic                  inc_i;
  logic                  dec_i;
  logic                  sr_i;
  logic                  ir_i;
  logic                  sl_i;
  logic                  il_i;
  logic [DATA_WIDTH-1:0] out_o;

  modport master (
    output cl_i, ld_i, in_i, inc_i, dec_i, sr_i, ir_i, sl_i, il_i,
    input  out_o
  );

  modport slave (
    input  cl_i, ld_i, in_i, inc_i, dec_i, sr_i, ir_i, sl_i, il_i,
    output out_o
  );
endinterface

// File: rtl/cpu_register.sv
// General-purpose datapath register: clear, load, increment, decrement and
// 1-bit shifts, resolved by fixed priority with one operation per clock.
module cpu_register #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_register_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_SHR,
    OP_SHL
  } op_e;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  op_e                   op;
  logic [DATA_WIDTH-1:0] reg_d;
  logic [DATA_WIDTH-1:0] reg_q;

  // A control counts only when it is a clean 1; an x/z condition falls
  // through to the next branch, so unconnected controls leave the state alone.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    op = OP_HOLD;
    if (bus.cl_i == 1'b1)       op = OP_CLR;
    else if (bus.ld_i == 1'b1)  op = OP_LOAD;
    else if (bus.inc_i == 1'b1) op = OP_INC;
    else if (bus.dec_i == 1'b1) op = OP_DEC;
    else if (bus.sr_i == 1'b1)  op = OP_SHR;
    else if (bus.sl_i == 1'b1)  op = OP_SHL;
  end

  always_comb begin
    reg_d = reg_q;
    case (op)
      OP_CLR:  reg_d = '0;
      OP_LOAD: reg_d = bus.in_i;
      OP_INC:  reg_d = reg_q + ONE;
      OP_DEC:  reg_d = reg_q - ONE;
      OP_SHR:  reg_d = {bus.ir_i, reg_q[DATA_WIDTH-1:1]};
      OP_SHL:  reg_d = {reg_q[DATA_WIDTH-2:0], bus.il_i};
      default: reg_d = reg_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  assign bus.out_o = reg_q;

endmodule

// File: tb/tb_cpu_register.sv
// Directed bench for cpu_register: 16-bit main instance, 6-bit instance with
// floating controls, and a 32-bit instance.
module tb_cpu_register;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  cpu_register_if #(16) u16 ();
  cpu_register_if #(6)  u6 ();
  cpu_register_if #(32) u32 ();

  cpu_register #(16) dut16 (.clk(clk), .rst_n(rst_n), .bus(u16.slave));
  cpu_register #(6)  dut6  (.clk(clk), .rst_n(rst_n), .bus(u6.slave));
  cpu_register #(32) dut32 (.clk(clk), .rst_n(rst_n), .bus(u32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the falling edge
  // that follows the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive16(input logic cl, input logic ld, input logic [15:0] din,
                         input logic inc, input logic dec, input logic sr,
                         input logic ir, input logic sl, input logic il);
    u16.cl_i  = cl;
    u16.ld_i  = ld;
    u16.in_i  = din;
    u16.inc_i = inc;
    u16.dec_i = dec;
    u16.sr_i  = sr;
    u16.ir_i  = ir;
    u16.sl_i  = sl;
    u16.il_i  = il;
  endtask

  task automatic idle16();
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tests_run++;
    if (u16.out_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset16: got %h expected %h", u16.out_o, 16'h0000);
    end
    tests_run++;
    if (u6.out_o !== 6'h00) begin
      tests_failed++;
      $display("FAIL reset6: got %h expected %h", u6.out_o, 6'h00);
    end
    tests_run++;
    if (u32.out_o !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reset32: got %h expected %h", u32.out_o, 32'h0000_0000);
    end
    rst_n = 1'b1;
    drive16(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL reset_preload: got %h expected %h", u16.out_o, 16'hBEEF);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (u16.out_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", u16.out_o, 16'h0000);
    end
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", u16.out_o, 16'h0000);
    end
    rst_n = 1'b1;
    drive16(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h1234) begin
      tests_failed++;
      $display("FAIL reset_release: got %h expected %h", u16.out_o, 16'h1234);
    end
    idle16();
  endtask

  task automatic test_load_clear();
    drive16(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h1234) begin
      tests_failed++;
      $display("FAIL load: got %h expected %h", u16.out_o, 16'h1234);
    end
    idle16();
    tick();
    tests_run++;
    if (u16.out_o !== 16'h1234) begin
      tests_failed++;
      $display("FAIL hold: got %h expected %h", u16.out_o, 16'h1234);
    end
    drive16(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL clear_over_load: got %h expected %h", u16.out_o, 16'h0000);
    end
    idle16();
  endtask

  task automatic test_inc_dec();
    drive16(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL load_ffff: got %h expected %h", u16.out_o, 16'hFFFF);
    end
    drive16(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL inc_wrap: got %h expected %h", u16.out_o, 16'h0000);
    end
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL dec_wrap: got %h expected %h", u16.out_o, 16'hFFFF);
    end
    drive16(1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0007) begin
      tests_failed++;
      $display("FAIL load_over_inc: got %h expected %h", u16.out_o, 16'h0007);
    end
    drive16(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0008) begin
      tests_failed++;
      $display("FAIL inc_over_dec: got %h expected %h", u16.out_o, 16'h0008);
    end
    idle16();
  endtask

  task automatic test_shift();
    drive16(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'hC000) begin
      tests_failed++;
      $display("FAIL shift_right: got %h expected %h", u16.out_o, 16'hC000);
    end
    drive16(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0002) begin
      tests_failed++;
      $display("FAIL shift_left: got %h expected %h", u16.out_o, 16'h0002);
    end
    drive16(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h4000) begin
      tests_failed++;
      $display("FAIL sr_over_sl: got %h expected %h", u16.out_o, 16'h4000);
    end
    drive16(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (u16.out_o !== 16'h0004) begin
      tests_failed++;
      $display("FAIL dec_over_sr: got %h expected %h", u16.out_o, 16'h0004);
    end
    idle16();
  endtask

  task automatic test_floating();
    u6.in_i = 6'h3F;
    u6.ld_i = 1'b1;
    tick();
    u6.ld_i = 1'b0;
    u6.in_i = 6'h00;
    tests_run++;
    if (u6.out_o !== 6'h3F) begin
      tests_failed++;
      $display("FAIL float_load: got %h expected %h", u6.out_o, 6'h3F);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (u6.out_o !== 6'h3F) begin
        tests_failed++;
        $display("FAIL float_idle%0d: got %h expected %h", i, u6.out_o, 6'h3F);
      end
    end
    u6.inc_i = 1'b1;
    tick();
    u6.inc_i = 1'bz;
    tests_run++;
    if (u6.out_o !== 6'h00) begin
      tests_failed++;
      $display("FAIL float_inc_wrap: got %h expected %h", u6.out_o, 6'h00);
    end
  endtask

  task automatic test_wide();
    u32.in_i = 32'hDEFE_DCBA;
    u32.ld_i = 1'b1;
    tick();
    u32.ld_i = 1'b0;
    tests_run++;
    if (u32.out_o !== 32'hDEFE_DCBA) begin
      tests_failed++;
      $display("FAIL wide_load: got %h expected %h", u32.out_o, 32'hDEFE_DCBA);
    end
    u32.cl_i = 1'b1;
    tick();
    u32.cl_i = 1'b0;
    tests_run++;
    if (u32.out_o !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL wide_clear: got %h expected %h", u32.out_o, 32'h0000_0000);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_seq [5];
    exp_seq[0] = 16'h00FF;
    exp_seq[1] = 16'h0100;
    exp_seq[2] = 16'h0201;
    exp_seq[3] = 16'h0100;
    exp_seq[4] = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive16(1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        1: drive16(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        2: drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        3: drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        default: drive16(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      tick();
      tests_run++;
      if (u16.out_o !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL b2b_step%0d: got %h expected %h", i, u16.out_o, exp_seq[i]);
      end
    end
    idle16();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle16();
    u6.cl_i  = 1'b0;
    u6.ld_i  = 1'b0;
    u6.in_i  = 6'h00;
    u6.inc_i = 1'bz;
    u6.dec_i = 1'bz;
    u6.sr_i  = 1'bz;
    u6.ir_i  = 1'bz;
    u6.sl_i  = 1'bz;
    u6.il_i  = 1'bz;
    u32.cl_i  = 1'b0;
    u32.ld_i  = 1'b0;
    u32.in_i  = 32'h0000_0000;
    u32.inc_i = 1'b0;
    u32.dec_i = 1'b0;
    u32.sr_i  = 1'b0;
    u32.ir_i  = 1'b0;
    u32.sl_i  = 1'b0;
    u32.il_i  = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_load_clear();
    test_inc_dec();
    test_shift();
    test_floating();
    test_wide();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
